prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer_pkg.sv | 6 +
 rtl/prog_sequencer_pc_next.sv | 19 +
 rtl/prog_sequencer.sv | 64 ++++++
 tb/tb_prog_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
// prog_sequencer_pkg: shared state encoding and widths for the program sequencer
package prog_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, MEMW, DONE} seq_state_t;
   localparam int PC_W = 10;
   localparam int CNT_W = 16;
endpackage

// File: rtl/prog_sequencer_pc_next.sv
// pc_next: next instruction address with goto > taken branch > increment priority
module pc_next
   import prog_sequencer_pkg::*;
(
   input  logic [PC_W-1:0] prog_ctr,
   input  logic            goto_en,
   input  logic            jump2_en,
   input  logic            branch_cond,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] next_pc
);
   logic [PC_W-1:0] offset;
   always_comb begin
      offset  = {{(PC_W-8){target[7]}}, target[7:0]};
      next_pc = goto_en ? target
              : (jump2_en && branch_cond) ? prog_ctr + offset
              : prog_ctr + PC_W'(1);
   end
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter FSM with memory stall, run-cycle counter and done handshake
module prog_sequencer
   import prog_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             ack,
   input  logic             goto_en,
   input  logic             jump2_en,
   input  logic             branch_cond,
   input  logic [PC_W-1:0]  target,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic [PC_W-1:0]  prog_ctr,
   output logic             commit,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count
);
   seq_state_t      state;
   logic [PC_W-1:0] next_pc;

   pc_next u_pc_next (
      .prog_ctr    (prog_ctr),
      .goto_en     (goto_en),
      .jump2_en    (jump2_en),
      .branch_cond (branch_cond),
      .target      (target),
      .next_pc     (next_pc)
   );

   assign busy = (state == RUN) || (state == MEMW);
   assign done = (state == DONE);
   // a reset cycle must never commit, so reset gates the write enable directly
   assign commit = reset && (((state == RUN) && !mem_access) || ((state == MEMW) && mem_ready));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         prog_ctr    <= '0;
         cycle_count <= '0;
      end else begin
         if (busy && (cycle_count != '1))
            cycle_count <= cycle_count + CNT_W'(1);
         case (state)
            IDLE: if (start) begin
               state       <= RUN;
               prog_ctr    <= '0;
               cycle_count <= '0;
            end
            RUN: if (ack) state <= DONE;
                 else if (mem_access) state <= MEMW;
                 else prog_ctr <= next_pc;
            MEMW: if (mem_ready) begin
               state    <= RUN;
               prog_ctr <= next_pc;
            end
            DONE: if (!start) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_prog_sequencer;
   logic clk = 0, reset = 0, start = 0, ack = 0, goto_en = 0, jump2_en = 0, branch_cond = 0;
   logic mem_access = 0, mem_ready = 0;
   logic [9:0] target = '0;
   logic [9:0] prog_ctr;
   logic commit, busy, done;
   logic [15:0] cycle_count;
   int tests = 0, fails = 0;
   int ms = 0, mpc = 0, mcnt = 0;
   localparam int S_IDLE = 0, S_RUN = 1, S_MEMW = 2, S_DONE = 3;

   prog_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .ack(ack), .goto_en(goto_en),
      .jump2_en(jump2_en), .branch_cond(branch_cond), .target(target),
      .mem_access(mem_access), .mem_ready(mem_ready), .prog_ctr(prog_ctr),
      .commit(commit), .busy(busy), .done(done), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   function automatic int model_npc();
      int off;
      off = int'(target[7:0]);
      if (off > 127) off -= 256;
      if (goto_en) return int'(target);
      if (jump2_en && branch_cond) return (mpc + off + 1024) % 1024;
      return (mpc + 1) % 1024;
   endfunction

   function automatic logic model_commit();
      return reset && ((ms == S_RUN && !mem_access) || (ms == S_MEMW && mem_ready));
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         ms = S_IDLE; mpc = 0; mcnt = 0;
      end else begin
         case (ms)
            S_IDLE: if (start) begin ms = S_RUN; mpc = 0; mcnt = 0; end
            S_RUN: begin
               mcnt = (mcnt < 65535) ? mcnt + 1 : mcnt;
               if (ack) ms = S_DONE;
               else if (mem_access) ms = S_MEMW;
               else mpc = model_npc();
            end
            S_MEMW: begin
               mcnt = (mcnt < 65535) ? mcnt + 1 : mcnt;
               if (mem_ready) begin mpc = model_npc(); ms = S_RUN; end
            end
            default: if (!start) ms = S_IDLE;
         endcase
      end
      #1;
   endtask

   task automatic clr();
      reset = 1; start = 0; ack = 0; goto_en = 0; jump2_en = 0; branch_cond = 0;
      mem_access = 0; mem_ready = 0; target = '0;
   endtask

   task automatic begin_run();
      clr(); start = 1; tick(); start = 0;
   endtask

   task automatic end_run();
      clr(); ack = 1; tick(); ack = 0; tick();
   endtask

   task automatic test_reset();
      reset = 0; mem_access = 0;
      tick(); tick();
      #1;
      tests++; if (prog_ctr !== 10'd0) begin fails++; $display("FAIL reset_pc got=%0d exp=0", prog_ctr); end
      tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", cycle_count); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
      tests++; if (commit !== 1'b0) begin fails++; $display("FAIL reset_commit got=%b exp=0", commit); end
      clr();
   endtask

   task automatic test_straight_run();
      begin_run();
      tests++; if (busy !== 1'b1 || cycle_count !== 16'd0) begin fails++; $display("FAIL run_start busy=%b cnt=%0d exp=1/0", busy, cycle_count); end
      for (int i = 0; i <= 5; i++) begin
         tests++; if (prog_ctr !== 10'(i)) begin fails++; $display("FAIL run_step got=%0d exp=%0d", prog_ctr, i); end
         ack = (i == 5);
         #1;
         tests++; if (commit !== 1'b1) begin fails++; $display("FAIL run_commit got=%b exp=1", commit); end
         tick();
      end
      ack = 0;
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL run_done done=%b busy=%b exp=1/0", done, busy); end
      tests++; if (cycle_count !== 16'd6) begin fails++; $display("FAIL run_cnt got=%0d exp=6", cycle_count); end
      tests++; if (prog_ctr !== 10'd5) begin fails++; $display("FAIL run_hold got=%0d exp=5", prog_ctr); end
      tick();
      tests++; if (done !== 1'b0 || cycle_count !== 16'd6) begin fails++; $display("FAIL run_idle done=%b cnt=%0d exp=0/6", done, cycle_count); end
   endtask

   task automatic test_branches();
      begin_run(); tick(); tick();
      goto_en = 1; target = 10'd300; tick();
      tests++; if (prog_ctr !== 10'd300) begin fails++; $display("FAIL goto got=%0d exp=300", prog_ctr); end
      goto_en = 0; jump2_en = 1; branch_cond = 1; target = 10'h0FE; tick();
      tests++; if (prog_ctr !== 10'd298) begin fails++; $display("FAIL jump2_taken got=%0d exp=298", prog_ctr); end
      jump2_en = 0; goto_en = 1; target = 10'd300; tick();
      goto_en = 0; jump2_en = 1; branch_cond = 0; target = 10'h0FE; tick();
      tests++; if (prog_ctr !== 10'd301) begin fails++; $display("FAIL jump2_not_taken got=%0d exp=301", prog_ctr); end
      goto_en = 1; jump2_en = 1; branch_cond = 1; target = 10'h0FE; tick();
      tests++; if (prog_ctr !== 10'd254) begin fails++; $display("FAIL goto_priority got=%0d exp=254", prog_ctr); end
      end_run();
   endtask

   task automatic test_mem_stall();
      begin_run();
      repeat (4) tick();
      mem_access = 1; tick();
      tests++; if (prog_ctr !== 10'd4 || busy !== 1'b1) begin fails++; $display("FAIL stall_enter pc=%0d busy=%b exp=4/1", prog_ctr, busy); end
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (commit !== 1'b0) begin fails++; $display("FAIL stall_commit got=%b exp=0", commit); end
         tick();
         tests++; if (prog_ctr !== 10'd4) begin fails++; $display("FAIL stall_hold got=%0d exp=4", prog_ctr); end
      end
      mem_ready = 1; mem_access = 0;
      #1;
      tests++; if (commit !== 1'b1) begin fails++; $display("FAIL stall_release_commit got=%b exp=1", commit); end
      tick(); mem_ready = 0;
      tests++; if (prog_ctr !== 10'd5) begin fails++; $display("FAIL stall_advance got=%0d exp=5", prog_ctr); end
      tests++; if (cycle_count !== 16'd9) begin fails++; $display("FAIL stall_cnt got=%0d exp=9", cycle_count); end
      end_run();
   endtask

   task automatic test_wrap_priority();
      begin_run();
      goto_en = 1; target = 10'd1023; tick();
      tests++; if (prog_ctr !== 10'd1023) begin fails++; $display("FAIL wrap_goto got=%0d exp=1023", prog_ctr); end
      goto_en = 0; tick();
      tests++; if (prog_ctr !== 10'd0) begin fails++; $display("FAIL wrap_step got=%0d exp=0", prog_ctr); end
      goto_en = 1; target = 10'd77; ack = 1; tick();
      tests++; if (done !== 1'b1 || prog_ctr !== 10'd0) begin fails++; $display("FAIL ack_priority done=%b pc=%0d exp=1/0", done, prog_ctr); end
      clr(); tick();
   endtask

   task automatic test_reset_mid_memw();
      begin_run();
      repeat (7) tick();
      mem_access = 1; tick();
      tests++; if (prog_ctr !== 10'd7 || busy !== 1'b1) begin fails++; $display("FAIL memw_setup pc=%0d busy=%b exp=7/1", prog_ctr, busy); end
      mem_ready = 1; reset = 0;
      #1;
      tests++; if (commit !== 1'b0) begin fails++; $display("FAIL reset_cycle_commit got=%b exp=0", commit); end
      tick();
      tests++; if (prog_ctr !== 10'd0 || cycle_count !== 16'd0) begin fails++; $display("FAIL memw_reset pc=%0d cnt=%0d exp=0/0", prog_ctr, cycle_count); end
      reset = 1;
      #1;
      tests++; if (busy !== 1'b0 || done !== 1'b0 || commit !== 1'b0) begin fails++; $display("FAIL memw_reset_flags busy=%b done=%b commit=%b exp=0/0/0", busy, done, commit); end
      clr(); tick();
   endtask

   task automatic test_handshake();
      begin_run();
      repeat (3) tick();
      ack = 1; start = 1; tick(); ack = 0;
      for (int i = 0; i < 3; i++) begin
         tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL hs_hold done=%b busy=%b exp=1/0", done, busy); end
         tick();
      end
      start = 0; tick();
      tests++; if (done !== 1'b0 || busy !== 1'b0 || cycle_count !== 16'd4) begin fails++; $display("FAIL hs_idle done=%b busy=%b cnt=%0d exp=0/0/4", done, busy, cycle_count); end
      start = 1; tick(); start = 0;
      tests++; if (busy !== 1'b1 || prog_ctr !== 10'd0 || cycle_count !== 16'd0) begin fails++; $display("FAIL hs_rerun busy=%b pc=%0d cnt=%0d exp=1/0/0", busy, prog_ctr, cycle_count); end
      tick();
      tests++; if (prog_ctr !== 10'd1 || cycle_count !== 16'd1) begin fails++; $display("FAIL hs_rerun_step pc=%0d cnt=%0d exp=1/1", prog_ctr, cycle_count); end
      end_run();
   endtask

   task automatic test_saturation();
      begin_run();
      mem_access = 1; tick();
      repeat (65540) tick();
      tests++; if (cycle_count !== 16'hFFFF) begin fails++; $display("FAIL sat_memw got=%h exp=ffff", cycle_count); end
      mem_ready = 1; tick(); mem_ready = 0; mem_access = 0;
      end_run();
      tests++; if (cycle_count !== 16'hFFFF || busy !== 1'b0) begin fails++; $display("FAIL sat_hold cnt=%h busy=%b exp=ffff/0", cycle_count, busy); end
   endtask

   task automatic test_random();
      reset = 0; tick();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) != 0);
         start = ($urandom_range(0, 3) == 0);
         ack = ($urandom_range(0, 9) == 0);
         goto_en = ($urandom_range(0, 5) == 0);
         jump2_en = ($urandom_range(0, 2) == 0);
         branch_cond = $urandom_range(0, 1) == 1;
         target = 10'($urandom_range(0, 1023));
         mem_access = ($urandom_range(0, 3) == 0);
         mem_ready = ($urandom_range(0, 2) == 0);
         #1;
         tests++; if (commit !== model_commit()) begin fails++; $display("FAIL rnd_commit cyc=%0d got=%b exp=%b", i, commit, model_commit()); end
         tick();
         tests++; if (prog_ctr !== 10'(mpc)) begin fails++; $display("FAIL rnd_pc cyc=%0d got=%0d exp=%0d", i, prog_ctr, mpc); end
         tests++; if (cycle_count !== 16'(mcnt)) begin fails++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, cycle_count, mcnt); end
         tests++; if (busy !== (ms == S_RUN || ms == S_MEMW) || done !== (ms == S_DONE)) begin fails++; $display("FAIL rnd_flags cyc=%0d busy=%b done=%b exp_state=%0d", i, busy, done, ms); end
      end
      clr(); reset = 0; tick(); clr();
   endtask

   initial begin
      test_reset();
      test_straight_run();
      test_branches();
      test_mem_stall();
      test_wrap_priority();
      test_reset_mid_memw();
      test_handshake();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
